// File: rtl/s7_display_mux.sv
// Multiplexed common-anode 7-segment driver: double-buffered digits, BCD/hex decode,
// leading-zero blanking and per-slot PWM brightness, all outputs registered.
module s7_display_mux #(
    parameter  int DIS_NUM = 4,
    parameter  int MLT_CNT = 10,
    localparam int CNT_W   = $clog2(MLT_CNT + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [DIS_NUM*4-1:0]   i_data,
    input  logic [DIS_NUM-1:0]     i_dp,
    input  logic                   i_load,
    input  logic                   i_hex_mode,
    input  logic                   i_lzb,
    input  logic [CNT_W-1:0]       i_duty,
    output logic [6:0]             o_segments,
    output logic                   o_dp,
    output logic [DIS_NUM-1:0]     o_segments_sel,
    output logic                   o_frame
);

    localparam int DIG_W = (DIS_NUM > 1) ? $clog2(DIS_NUM) : 1;

    logic [DIS_NUM*4-1:0] r_shadow_data;
    logic [DIS_NUM-1:0]   r_shadow_dp;
    logic [DIS_NUM*4-1:0] r_buf_data;
    logic [DIS_NUM-1:0]   r_buf_dp;
    logic                 r_hex;
    logic                 r_lzb;
    logic [CNT_W-1:0]     r_duty;
    logic [CNT_W-1:0]     r_slot;
    logic [DIG_W-1:0]     r_digit;
    logic                 r_run;

    logic                 w_last;
    logic                 w_wrap;
    logic                 w_slot_end;
    logic [3:0]           w_nibble;
    logic                 w_blank;
    logic                 w_run_zero;
    logic [6:0]           w_seg;
    logic [DIS_NUM-1:0]   w_sel;

    function automatic logic [6:0] f_decode(input logic [3:0] nib, input logic hex);
        case (nib)
            4'h0:    f_decode = 7'b0000001;
            4'h1:    f_decode = 7'b1001111;
            4'h2:    f_decode = 7'b0010010;
            4'h3:    f_decode = 7'b0000110;
            4'h4:    f_decode = 7'b1001100;
            4'h5:    f_decode = 7'b0100100;
            4'h6:    f_decode = 7'b0100000;
            4'h7:    f_decode = 7'b0001111;
            4'h8:    f_decode = 7'b0000000;
            4'h9:    f_decode = 7'b0000100;
            4'hA:    f_decode = hex ? 7'b0001000 : 7'b1111110;
            4'hB:    f_decode = hex ? 7'b1100000 : 7'b1111110;
            4'hC:    f_decode = hex ? 7'b0110001 : 7'b1111110;
            4'hD:    f_decode = hex ? 7'b1000010 : 7'b1111110;
            4'hE:    f_decode = hex ? 7'b0110000 : 7'b1111110;
            4'hF:    f_decode = hex ? 7'b0111000 : 7'b1111110;
            default: f_decode = 7'b1111110;
        endcase
    endfunction

    // Scan position, wrap detection, blanking and the next output values.
    always_comb begin
        w_slot_end = (r_slot == CNT_W'(MLT_CNT - 1));
        w_last     = r_run && w_slot_end && (r_digit == DIG_W'(DIS_NUM - 1));
        // The first edge after reset release is itself a wrap, so frame 0 starts loaded.
        w_wrap     = !r_run || w_last;
        w_nibble   = r_buf_data[{r_digit, 2'b00} +: 4];
        w_run_zero = 1'b1;
        w_blank    = 1'b0;
        for (int k = DIS_NUM - 1; k >= 0; k--) begin
            w_run_zero = w_run_zero && (r_buf_data[4*k +: 4] == 4'h0);
            w_blank    = w_blank || (r_lzb && w_run_zero && (k != 0) && (r_digit == DIG_W'(k)));
        end
        if (w_blank) begin
            w_seg = 7'h7F;
        end else begin
            w_seg = f_decode(w_nibble, r_hex);
        end
        if (r_slot < r_duty) begin
            w_sel = ~({{(DIS_NUM-1){1'b0}}, 1'b1} << r_digit);
        end else begin
            w_sel = {DIS_NUM{1'b1}};
        end
    end

    // Shadow capture, frame-boundary buffer/setting latch and scan counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_buf_data    <= '0;
            r_buf_dp      <= '0;
            r_hex         <= 1'b0;
            r_lzb         <= 1'b0;
            r_duty        <= '0;
            r_slot        <= '0;
            r_digit       <= '0;
            r_run         <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (i_load) begin
                r_shadow_data <= i_data;
                r_shadow_dp   <= i_dp;
            end
            if (w_wrap) begin
                r_buf_data <= r_shadow_data;
                r_buf_dp   <= r_shadow_dp;
                r_hex      <= i_hex_mode;
                r_lzb      <= i_lzb;
                r_duty     <= i_duty;
                r_slot     <= '0;
                r_digit    <= '0;
            end else if (w_slot_end) begin
                r_slot  <= '0;
                r_digit <= r_digit + DIG_W'(1);
            end else begin
                r_slot <= r_slot + CNT_W'(1);
            end
        end
    end

    // Registered pin drivers; held dark on the release edge until the first frame starts.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_segments     <= 7'h7F;
            o_dp           <= 1'b1;
            o_segments_sel <= {DIS_NUM{1'b1}};
            o_frame        <= 1'b0;
        end else if (r_run) begin
            o_segments     <= w_seg;
            o_dp           <= ~r_buf_dp[r_digit];
            o_segments_sel <= w_sel;
            o_frame        <= w_last;
        end else begin
            o_segments     <= 7'h7F;
            o_dp           <= 1'b1;
            o_segments_sel <= {DIS_NUM{1'b1}};
            o_frame        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s7_display_mux.sv
// Directed plus random stimulus for s7_display_mux, checked every cycle against a
// cycle-index model of the scan (output cycle n shows position (n-1) mod frame).
module tb_s7_display_mux;

    localparam int N  = 4;
    localparam int M  = 10;
    localparam int CW = $clog2(M + 1);
    localparam int FP = N * M;

    localparam logic [6:0] BCD_TAB [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                            7'h00, 7'h04, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
    localparam logic [6:0] HEX_TAB [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   data;
    logic [3:0]    dp;
    logic          load;
    logic          hex;
    logic          lzb;
    logic [CW-1:0] duty;
    logic [6:0]    seg;
    logic          dpo;
    logic [3:0]    sel;
    logic          frame;

    int tests = 0;
    int fails = 0;
    int n     = -1;

    logic [15:0] m_sh, m_buf;
    logic [3:0]  m_shdp, m_bufdp;
    logic        m_hex, m_lzb;
    int          m_duty;

    always #5 clk = ~clk;

    s7_display_mux #(.DIS_NUM(N), .MLT_CNT(M)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_data         (data),
        .i_dp           (dp),
        .i_load         (load),
        .i_hex_mode     (hex),
        .i_lzb          (lzb),
        .i_duty         (duty),
        .o_segments     (seg),
        .o_dp           (dpo),
        .o_segments_sel (sel),
        .o_frame        (frame)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h out_cycle=%0d", tag, obs, exp, n);
        end
    endtask

    // One clock: predict outputs of this edge, update the model, then compare.
    task automatic step();
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_sel;
        logic       e_fr;
        int         nc, p, d, s;
        logic [15:0] upper;
        e_seg = 7'h7F; e_dp = 1'b1; e_sel = 4'hF; e_fr = 1'b0;
        if (!rst) begin
            m_sh = 16'h0; m_buf = 16'h0; m_shdp = 4'h0; m_bufdp = 4'h0;
            m_hex = 1'b0; m_lzb = 1'b0; m_duty = 0; n = -1;
        end else begin
            nc = n + 1;
            if (nc > 0) begin
                p = (nc - 1) % FP;
                d = p / M;
                s = p % M;
                upper = m_buf >> (4 * d);
                if (m_lzb && d > 0 && upper == 16'h0)
                    e_seg = 7'h7F;
                else if (m_hex)
                    e_seg = HEX_TAB[upper[3:0]];
                else
                    e_seg = BCD_TAB[upper[3:0]];
                e_dp  = ~m_bufdp[d];
                e_sel = (s < m_duty) ? ~(4'b0001 << d) : 4'hF;
                e_fr  = (nc % FP == 0);
            end
            if (nc % FP == 0) begin
                m_buf = m_sh; m_bufdp = m_shdp;
                m_hex = hex; m_lzb = lzb; m_duty = int'(duty);
            end
            if (load) begin
                m_sh = data; m_shdp = dp;
            end
            n = nc;
        end
        @(posedge clk);
        #1;
        chk("segments", {9'h0, seg}, {9'h0, e_seg});
        chk("dp", {15'h0, dpo}, {15'h0, e_dp});
        chk("select", {12'h0, sel}, {12'h0, e_sel});
        chk("frame", {15'h0, frame}, {15'h0, e_fr});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        rst = 1'b0; data = 16'h0; dp = 4'h0; load = 1'b0;
        hex = 1'b0; lzb = 1'b0; duty = '0;
        run(3);

        // Full-brightness BCD scan of 1234.
        rst = 1'b1; data = 16'h1234; load = 1'b1; duty = CW'(M);
        step();
        load = 1'b0;
        run(2 * FP + 2);

        // Hex versus BCD decode of AbCF.
        data = 16'hABCF; load = 1'b1; step(); load = 1'b0;
        hex = 1'b1; run(2 * FP);
        hex = 1'b0; run(FP);

        // Leading-zero blanking, with a dp on a blanked digit.
        lzb = 1'b1; data = 16'h0070; dp = 4'b0100; load = 1'b1; step(); load = 1'b0;
        run(2 * FP);
        data = 16'h0000; dp = 4'b0000; load = 1'b1; step(); load = 1'b0;
        run(2 * FP);

        // Duty cycle: 3, dark, then a mid-frame change.
        lzb = 1'b0; data = 16'h1234; load = 1'b1; step(); load = 1'b0;
        duty = CW'(3); run(2 * FP);
        duty = '0; run(FP + 5);
        duty = CW'(7); run(2 * FP);
        duty = CW'(15); run(FP);

        // Load exactly on the wrap edge, then data changes without a load.
        while (((n + 1) % FP) != 0) step();
        data = 16'h5678; dp = 4'b1001; load = 1'b1; step(); load = 1'b0;
        data = 16'h9999; run(2 * FP);

        // Reset while digit 2 is being scanned.
        while (((n % FP) / M) != 2) step();
        rst = 1'b0; step();
        rst = 1'b1; run(FP + 3);

        // Random traffic including occasional resets and setting changes.
        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(0, 299) != 0);
            load = ($urandom_range(0, 7) == 0);
            data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
            dp   = 4'($urandom);
            if ($urandom_range(0, 30) == 0) hex  = ~hex;
            if ($urandom_range(0, 30) == 0) lzb  = ~lzb;
            if ($urandom_range(0, 30) == 0) duty = CW'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
